// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition-code register, branch/cmov condition
// evaluation and a RUN/HALT/ERR status machine with a one-cycle registered result.
module execute_stage #(
    parameter int unsigned W          = 64,
    parameter int unsigned STACK_STEP = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [3:0]   icode,
    input  logic [3:0]   ifun,
    input  logic [W-1:0] valA,
    input  logic [W-1:0] valB,
    input  logic [W-1:0] valC,
    output logic         out_valid,
    output logic [W-1:0] valE,
    output logic         cnd,
    output logic         zf,
    output logic         sf,
    output logic         of,
    output logic [1:0]   stat
);

    typedef enum logic [1:0] {
        S_RUN  = 2'b00,
        S_HALT = 2'b01,
        S_ERR  = 2'b10
    } state_t;

    state_t         r_state;
    logic           w_accept;
    logic [W-1:0]   w_vale;
    logic           w_cnd;
    logic           w_cond;
    logic           w_cond_ok;
    logic           w_err;
    logic           w_halt;
    logic           w_cc_upd;
    logic           w_of;

    assign w_accept = in_valid && (r_state == S_RUN);
    assign stat     = r_state;

    // Condition evaluated against the CC value held before this edge
    always_comb begin
        w_cond    = 1'b0;
        w_cond_ok = 1'b1;
        case (ifun)
            4'h0:    w_cond = 1'b1;
            4'h1:    w_cond = (sf ^ of) | zf;
            4'h2:    w_cond = sf ^ of;
            4'h3:    w_cond = zf;
            4'h4:    w_cond = !zf;
            4'h5:    w_cond = !(sf ^ of);
            4'h6:    w_cond = !(sf ^ of) && !zf;
            default: w_cond_ok = 1'b0;
        endcase
    end

    // Result, flag and status decision for the instruction on the inputs
    always_comb begin
        w_vale   = '0;
        w_cnd    = 1'b0;
        w_err    = 1'b0;
        w_halt   = 1'b0;
        w_cc_upd = 1'b0;
        w_of     = 1'b0;
        case (icode)
            4'h0: w_halt = 1'b1;
            4'h1: w_vale = '0;
            4'h2: begin
                w_vale = valA;
                w_cnd  = w_cond;
                w_err  = !w_cond_ok;
            end
            4'h3: w_vale = valC;
            4'h4, 4'h5: w_vale = valB + valC;
            4'h6: begin
                w_cc_upd = 1'b1;
                case (ifun)
                    4'h0: begin
                        w_vale = valB + valA;
                        w_of   = (valA[W-1] == valB[W-1]) && (w_vale[W-1] != valA[W-1]);
                    end
                    4'h1: begin
                        w_vale = valB - valA;
                        w_of   = (valA[W-1] != valB[W-1]) && (w_vale[W-1] != valB[W-1]);
                    end
                    4'h2: w_vale = valB & valA;
                    4'h3: w_vale = valB ^ valA;
                    default: w_err = 1'b1;
                endcase
            end
            4'h7: begin
                w_cnd = w_cond;
                w_err = !w_cond_ok;
            end
            4'h8, 4'hA: w_vale = valB - W'(STACK_STEP);
            4'h9, 4'hB: w_vale = valB + W'(STACK_STEP);
            default: w_err = 1'b1;
        endcase
        if (w_err) begin
            w_vale   = '0;
            w_cnd    = 1'b0;
            w_cc_upd = 1'b0;
            w_of     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RUN;
            out_valid <= 1'b0;
            valE      <= '0;
            cnd       <= 1'b0;
            zf        <= 1'b1;
            sf        <= 1'b0;
            of        <= 1'b0;
        end else begin
            out_valid <= w_accept;
            if (w_accept) begin
                valE <= w_vale;
                cnd  <= w_cnd;
                if (w_cc_upd) begin
                    zf <= (w_vale == '0);
                    sf <= w_vale[W-1];
                    of <= w_of;
                end
                if (w_err) begin
                    r_state <= S_ERR;
                end else if (w_halt) begin
                    r_state <= S_HALT;
                end
            end
        end
    end

endmodule
